// File: rtl/autoref_scheduler.sv
// Auto-refresh scheduler: interval ticks, owed-refresh accounting and the tRFC busy window.
// Outputs are registered (one-cycle latency from inputs); the arbiter applies backpressure by withholding ref_ack.
module autoref_scheduler #(
    parameter int CNT_W        = 28,
    parameter int MAX_POSTPONE = 8,
    parameter int OWED_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             aref_en,
    input  logic [CNT_W-1:0] aref_interval,
    input  logic [CNT_W-1:0] trfc,
    input  logic             ref_ack,
    output logic             ref_req,
    output logic             ref_urgent,
    output logic             ref_busy,
    output logic [OWED_W-1:0] owed_cnt,
    output logic             ref_overflow
);

    typedef enum logic [1:0] {OFF, IDLE, RFC} state_t;

    localparam logic [OWED_W-1:0] OWED_MAX = OWED_W'(MAX_POSTPONE);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  ivl_cnt;
    logic [CNT_W-1:0]  rfc_cnt;
    logic [CNT_W-1:0]  trfc_eff;
    logic [OWED_W-1:0] owed_nxt;
    logic              ovf_nxt;
    logic              en_eff;
    logic              tick;
    logic              accept;
    logic              rfc_done;

    always_comb begin
        en_eff   = aref_en && (aref_interval != '0);
        // >= so that shrinking the interval below the running count ticks at once
        tick     = en_eff && (ivl_cnt >= (aref_interval - CNT_W'(1)));
        accept   = ref_ack && ref_req;
        rfc_done = (state == RFC) && (rfc_cnt == CNT_W'(1));
        trfc_eff = (trfc == '0) ? CNT_W'(1) : trfc;

        owed_nxt = owed_cnt;
        ovf_nxt  = ref_overflow;
        if (!en_eff) begin
            owed_nxt = '0;
            ovf_nxt  = 1'b0;
        end else if (tick && !accept) begin
            if (owed_cnt == OWED_MAX)
                ovf_nxt = 1'b1;
            else
                owed_nxt = owed_cnt + OWED_W'(1);
        end else if (accept && !tick) begin
            owed_nxt = owed_cnt - OWED_W'(1);
        end

        state_nxt = state;
        case (state)
            OFF:  state_nxt = en_eff ? IDLE : OFF;
            // an issued REF always opens the window, even if enable drops on the same edge
            IDLE: state_nxt = accept ? RFC : (en_eff ? IDLE : OFF);
            RFC:  state_nxt = rfc_done ? (en_eff ? IDLE : OFF) : RFC;
            default: state_nxt = OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= OFF;
            ivl_cnt      <= '0;
            rfc_cnt      <= '0;
            owed_cnt     <= '0;
            ref_overflow <= 1'b0;
            ref_req      <= 1'b0;
            ref_urgent   <= 1'b0;
            ref_busy     <= 1'b0;
        end else begin
            state        <= state_nxt;
            ivl_cnt      <= (!en_eff || tick) ? '0 : ivl_cnt + CNT_W'(1);
            owed_cnt     <= owed_nxt;
            ref_overflow <= ovf_nxt;
            if (accept)
                rfc_cnt <= trfc_eff;
            else if (state == RFC && rfc_cnt != '0)
                rfc_cnt <= rfc_cnt - CNT_W'(1);
            ref_busy     <= (state_nxt == RFC);
            ref_req      <= (state_nxt == IDLE) && (owed_nxt != '0);
            ref_urgent   <= (owed_nxt == OWED_MAX);
        end
    end

endmodule

// File: tb/tb_autoref_scheduler.sv
// Directed scenarios plus randomized traffic against a timestamp-based reference model.
module tb_autoref_scheduler;

    localparam int CNT_W  = 28;
    localparam int MAXP   = 8;
    localparam int OWED_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              aref_en;
    logic [CNT_W-1:0]  aref_interval;
    logic [CNT_W-1:0]  trfc;
    logic              ref_ack;
    logic              ref_req;
    logic              ref_urgent;
    logic              ref_busy;
    logic [OWED_W-1:0] owed_cnt;
    logic              ref_overflow;

    autoref_scheduler #(.CNT_W(CNT_W), .MAX_POSTPONE(MAXP), .OWED_W(OWED_W)) dut (
        .clk(clk), .rst(rst), .aref_en(aref_en), .aref_interval(aref_interval),
        .trfc(trfc), .ref_ack(ref_ack), .ref_req(ref_req), .ref_urgent(ref_urgent),
        .ref_busy(ref_busy), .owed_cnt(owed_cnt), .ref_overflow(ref_overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: absolute edge count, edge of the last tick (or enable anchor), and last busy edge.
    longint cyc = 0;
    longint anchor = 0;
    longint busy_end = -1;
    int     m_owed = 0;
    bit     m_ovf = 0;
    bit     m_req = 0;
    bit     m_busy = 0;
    int     mode = 0;      // 0 ack low, 1 ack follows req, 2 random, 3 hold, 4 ack high
    int     busy_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit en, acc, tk;
        cyc++;
        if (rst) begin
            anchor = cyc; busy_end = -1; m_owed = 0; m_ovf = 0; m_req = 0; m_busy = 0;
            return;
        end
        en  = aref_en && (aref_interval != 0);
        acc = ref_ack && m_req;
        tk  = 0;
        if (!en)
            anchor = cyc;
        else if (cyc - anchor >= longint'(aref_interval)) begin
            tk = 1;
            anchor = cyc;
        end
        if (acc)
            busy_end = cyc + ((trfc == 0) ? 1 : longint'(trfc)) - 1;
        if (!en) begin
            m_owed = 0; m_ovf = 0;
        end else if (tk && !acc) begin
            if (m_owed == MAXP) m_ovf = 1; else m_owed++;
        end else if (acc && !tk) begin
            m_owed--;
        end
        m_busy = (cyc <= busy_end);
        m_req  = en && !m_busy && (m_owed != 0);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: ref_ack = 1'b0;
                1: ref_ack = m_req;
                2: ref_ack = ($urandom % 3 == 0);
                4: ref_ack = 1'b1;
                default: ;
            endcase
            @(posedge clk);
            model_edge();
            #1;
            chk("req", ref_req, m_req);
            chk("busy", ref_busy, m_busy);
            chk("owed", owed_cnt, m_owed);
            chk("urgent", ref_urgent, (m_owed == MAXP));
            chk("overflow", ref_overflow, m_ovf);
            if (ref_busy) busy_seen++;
        end
    endtask

    initial begin
        rst = 1'b1; aref_en = 1'b0; aref_interval = '0; trfc = '0; ref_ack = 1'b0;
        step(2);
        chk("reset_req", ref_req, 0);
        chk("reset_busy", ref_busy, 0);
        chk("reset_owed", owed_cnt, 0);
        rst = 1'b0;

        // T1: first request exactly 100 cycles after enable, 10-cycle busy window
        aref_interval = 100; trfc = 10; aref_en = 1'b1; mode = 1;
        step(99);
        chk("t1_req_early", ref_req, 0);
        step(1);
        chk("t1_req_rise", ref_req, 1);
        busy_seen = 0;
        step(20);
        chk("t1_busy_len", busy_seen, 10);
        chk("t1_owed_zero", owed_cnt, 0);

        // T2: no acks, saturation at 8 and overflow on the 9th tick
        aref_en = 1'b0; mode = 0; step(1);
        aref_interval = 20; aref_en = 1'b1;
        step(160);
        chk("t2_owed8", owed_cnt, 8);
        chk("t2_urgent", ref_urgent, 1);
        chk("t2_no_ovf_yet", ref_overflow, 0);
        step(40);
        chk("t2_owed_sat", owed_cnt, 8);
        chk("t2_ovf", ref_overflow, 1);

        // T3: accept coincident with the 9th tick at saturation
        aref_en = 1'b0; step(1);
        aref_en = 1'b1;
        step(179);
        chk("t3_owed8", owed_cnt, 8);
        mode = 3; ref_ack = 1'b1;
        step(1);
        mode = 0;
        chk("t3_owed_hold", owed_cnt, 8);
        chk("t3_no_ovf", ref_overflow, 0);
        step(15);

        // T4: trfc=0 gives a one-cycle window; ack held high during it is ignored
        aref_en = 1'b0; step(1);
        trfc = 0; aref_interval = 5; aref_en = 1'b1; mode = 4; busy_seen = 0;
        step(30);
        chk("t4_busy_cycles", busy_seen, 5);
        mode = 0;

        // T5: enable dropped 3 cycles into a 10-cycle window
        aref_en = 1'b0; step(1);
        trfc = 10; aref_interval = 8; aref_en = 1'b1;
        step(8);
        chk("t5_req", ref_req, 1);
        mode = 3; ref_ack = 1'b1; step(1);
        ref_ack = 1'b0; mode = 0;
        step(2);
        aref_en = 1'b0; busy_seen = 0;
        step(1);
        chk("t5_owed_clear", owed_cnt, 0);
        chk("t5_req_drop", ref_req, 0);
        chk("t5_still_busy", ref_busy, 1);
        step(12);
        chk("t5_busy_rest", busy_seen, 7);

        // T6: reset pulsed mid-window with 5 owed
        aref_en = 1'b0; step(1);
        aref_interval = 4; trfc = 20; aref_en = 1'b1;
        step(20);
        chk("t6_owed5", owed_cnt, 5);
        mode = 3; ref_ack = 1'b1; step(1);
        ref_ack = 1'b0; mode = 0;
        step(3);
        chk("t6_owed_mid", owed_cnt, 5);
        chk("t6_busy_mid", ref_busy, 1);
        rst = 1'b1; step(1);
        chk("t6_busy", ref_busy, 0);
        chk("t6_owed", owed_cnt, 0);
        chk("t6_req", ref_req, 0);
        rst = 1'b0;

        // Randomized traffic: config changes mid-flight, random acks, occasional reset
        mode = 2;
        for (int b = 0; b < 40; b++) begin
            aref_interval = CNT_W'($urandom % 13);
            trfc          = CNT_W'($urandom % 7);
            aref_en       = ($urandom % 6 != 0);
            if ($urandom % 10 == 0) begin
                rst = 1'b1; step(1); rst = 1'b0;
            end
            step(50);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
